// File: rtl/axi_err_slv_pkg.sv
// Shared types and constants for the DECERR terminating AXI4 responder.
package axi_err_slv_pkg;

  localparam int unsigned IdWidthSlave = 6;
  localparam int unsigned AddrWidth    = 64;
  localparam int unsigned DataWidth    = 64;
  localparam int unsigned UserWidth    = 1;

  localparam logic [1:0]  RESP_DECERR       = 2'b11;
  localparam logic [63:0] RESP_DATA_DEFAULT = 64'hBADC_AB1E_BADC_AB1E;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  typedef struct packed {
    logic [IdWidthSlave-1:0] id;
    logic [AddrWidth-1:0]    addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [5:0]              atop;
    logic [UserWidth-1:0]    user;
  } axi_aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
    logic [UserWidth-1:0]   user;
  } axi_w_chan_t;

  typedef struct packed {
    logic [IdWidthSlave-1:0] id;
    logic [AddrWidth-1:0]    addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [UserWidth-1:0]    user;
  } axi_ar_chan_t;

  typedef struct packed {
    logic [IdWidthSlave-1:0] id;
    logic [1:0]              resp;
    logic [UserWidth-1:0]    user;
  } axi_b_chan_t;

  typedef struct packed {
    logic [IdWidthSlave-1:0] id;
    logic [DataWidth-1:0]    data;
    logic [1:0]              resp;
    logic                    last;
    logic [UserWidth-1:0]    user;
  } axi_r_chan_t;

  typedef struct packed {
    axi_aw_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_resp_t;

endpackage

// File: rtl/axi_err_slv_rd.sv
// Read-side FSM of the error responder: accepts one AR and returns arlen+1 DECERR beats.
module axi_err_slv_rd
  import axi_err_slv_pkg::*;
#(
  parameter int unsigned IdWidth = IdWidthSlave
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ar_valid,
  input  logic [IdWidth-1:0] ar_id,
  input  logic [7:0]         ar_len,
  input  logic               r_ready,
  output logic               ar_ready,
  output logic               r_valid,
  output logic [IdWidth-1:0] r_id,
  output logic               r_last
);

  r_state_e   state;
  logic [7:0] cnt;

  // r_last is precomputed from the counter so it never depends on r_ready combinationally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= R_IDLE;
      ar_ready <= 1'b1;
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_last   <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        R_IDLE: begin
          if (ar_valid) begin
            state    <= R_DATA;
            ar_ready <= 1'b0;
            r_valid  <= 1'b1;
            r_id     <= ar_id;
            cnt      <= ar_len;
            r_last   <= (ar_len == 8'd0);
          end
        end
        R_DATA: begin
          if (r_ready) begin
            if (r_last) begin
              state    <= R_IDLE;
              ar_ready <= 1'b1;
              r_valid  <= 1'b0;
              r_last   <= 1'b0;
            end else begin
              cnt    <= cnt - 8'd1;
              r_last <= (cnt == 8'd1);
            end
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi_err_slv.sv
// AXI4 terminating slave answering every burst with DECERR; optional fault capture
// (address, pulse, saturating count) enabled by defining ERR_SLV_CAPTURE_EN.
module axi_err_slv
  import axi_err_slv_pkg::*;
#(
  parameter int unsigned             AxiIdWidth   = IdWidthSlave,
  parameter int unsigned             AxiAddrWidth = 64,
  parameter int unsigned             AxiDataWidth = 64,
  parameter logic [AxiDataWidth-1:0] RespData     = RESP_DATA_DEFAULT,
  parameter type                     req_t        = axi_req_t,
  parameter type                     resp_t       = axi_resp_t
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  req_t                    axi_req_i,
  output resp_t                   axi_resp_o,
  output logic                    err_valid_o,
  output logic [AxiAddrWidth-1:0] err_addr_o,
  output logic [15:0]             err_cnt_o
);

  w_state_e              w_state;
  logic                  aw_ready, w_ready, b_valid;
  logic [AxiIdWidth-1:0] b_id;
  logic                  ar_ready, r_valid, r_last;
  logic [AxiIdWidth-1:0] r_id;
  logic                  aw_hs, ar_hs;

  assign aw_hs = axi_req_i.aw_valid & aw_ready;
  assign ar_hs = axi_req_i.ar_valid & ar_ready;

  // Write side: awlen and atop are ignored, only wlast closes the burst
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state  <= W_IDLE;
      aw_ready <= 1'b1;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_id     <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            w_state  <= W_DATA;
            aw_ready <= 1'b0;
            w_ready  <= 1'b1;
            b_id     <= axi_req_i.aw.id;
          end
        end
        W_DATA: begin
          if (axi_req_i.w_valid && axi_req_i.w.last) begin
            w_state <= W_RESP;
            w_ready <= 1'b0;
            b_valid <= 1'b1;
          end
        end
        W_RESP: begin
          if (axi_req_i.b_ready) begin
            w_state  <= W_IDLE;
            b_valid  <= 1'b0;
            aw_ready <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  axi_err_slv_rd #(
    .IdWidth (AxiIdWidth)
  ) u_rd (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .ar_valid (axi_req_i.ar_valid),
    .ar_id    (axi_req_i.ar.id),
    .ar_len   (axi_req_i.ar.len),
    .r_ready  (axi_req_i.r_ready),
    .ar_ready (ar_ready),
    .r_valid  (r_valid),
    .r_id     (r_id),
    .r_last   (r_last)
  );

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_ready;
    axi_resp_o.w_ready  = w_ready;
    axi_resp_o.b_valid  = b_valid;
    axi_resp_o.b.id     = b_id;
    axi_resp_o.b.resp   = RESP_DECERR;
    axi_resp_o.ar_ready = ar_ready;
    axi_resp_o.r_valid  = r_valid;
    axi_resp_o.r.id     = r_id;
    axi_resp_o.r.data   = RespData;
    axi_resp_o.r.resp   = RESP_DECERR;
    axi_resp_o.r.last   = r_last;
  end

`ifdef ERR_SLV_CAPTURE_EN
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic                    err_valid_q;
  logic [AxiAddrWidth-1:0] err_addr_q;
  logic [15:0]             err_cnt_q;

  // A simultaneous AW and AR counts twice but only the AW address is kept
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      err_valid_q <= aw_hs | ar_hs;
      if (aw_hs)      err_addr_q <= axi_req_i.aw.addr;
      else if (ar_hs) err_addr_q <= axi_req_i.ar.addr;
      err_cnt_q <= sat_add(err_cnt_q, {1'b0, aw_hs} + {1'b0, ar_hs});
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;
  assign err_cnt_o   = err_cnt_q;
`else
  assign err_valid_o = 1'b0;
  assign err_addr_o  = '0;
  assign err_cnt_o   = '0;
`endif

  // Payload fields (wdata, strb, sizes, users) are deliberately discarded
  logic unused;
  assign unused = ^{axi_req_i, aw_hs, ar_hs};

endmodule

// File: tb/tb_axi_err_slv.sv
// Self-checking bench for axi_err_slv: vector table plus hand-written corner sequences.
module tb_axi_err_slv;
  import axi_err_slv_pkg::*;

`ifdef ERR_SLV_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif
  localparam logic [63:0] RDATA = 64'hBADC_AB1E_BADC_AB1E;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  axi_req_t    req;
  axi_resp_t   resp;
  logic        err_valid;
  logic [63:0] err_addr;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  axi_err_slv dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .axi_req_i   (req),
    .axi_resp_o  (resp),
    .err_valid_o (err_valid),
    .err_addr_o  (err_addr),
    .err_cnt_o   (err_cnt)
  );

  typedef struct packed {logic [5:0] id; logic last;} rexp_t;
  typedef struct {
    bit         rd;
    logic [5:0] id;
    logic [7:0] len;
    int         wbeats;
    logic [5:0] atop;
    int         exp_beats;
  } vec_t;

  rexp_t      rq[$];
  logic [5:0] bq[$];
  int nassert = 0, nfail = 0;
  int rbeats = 0, bbeats = 0;
  int exp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nassert++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: scoreboard pops and stall-stability checks
  logic        prv_rv, prv_rr, prv_rl, prv_bv, prv_br;
  logic [5:0]  prv_rid, prv_bid;
  logic [63:0] prv_rd;
  always @(negedge clk) begin
    rexp_t e;
    logic [5:0] eb;
    if (!rst_n) begin
      prv_rv = 1'b0;
      prv_bv = 1'b0;
    end else begin
      if (prv_rv && !prv_rr) begin
        check("r_hold_valid", {63'd0, resp.r_valid}, 64'd1);
        check("r_hold_id", {58'd0, resp.r.id}, {58'd0, prv_rid});
        check("r_hold_last", {63'd0, resp.r.last}, {63'd0, prv_rl});
        check("r_hold_data", resp.r.data, prv_rd);
      end
      if (prv_bv && !prv_br) begin
        check("b_hold_valid", {63'd0, resp.b_valid}, 64'd1);
        check("b_hold_id", {58'd0, resp.b.id}, {58'd0, prv_bid});
      end
      if (resp.r_valid && req.r_ready) begin
        if (rq.size() == 0) check("r_unexpected_beat", 64'd1, 64'd0);
        else begin
          e = rq.pop_front();
          check("r_id", {58'd0, resp.r.id}, {58'd0, e.id});
          check("r_last", {63'd0, resp.r.last}, {63'd0, e.last});
          check("r_data", resp.r.data, RDATA);
          check("r_resp", {62'd0, resp.r.resp}, 64'd3);
        end
        rbeats++;
      end
      if (resp.b_valid && req.b_ready) begin
        if (bq.size() == 0) check("b_unexpected", 64'd1, 64'd0);
        else begin
          eb = bq.pop_front();
          check("b_id", {58'd0, resp.b.id}, {58'd0, eb});
          check("b_resp", {62'd0, resp.b.resp}, 64'd3);
          check("b_user", {63'd0, resp.b.user}, 64'd0);
        end
        bbeats++;
      end
      prv_rv = resp.r_valid; prv_rr = req.r_ready; prv_rl = resp.r.last;
      prv_rid = resp.r.id;   prv_rd = resp.r.data;
      prv_bv = resp.b_valid; prv_br = req.b_ready; prv_bid = resp.b.id;
    end
  end

  task automatic do_write(input logic [5:0] id, input logic [7:0] len, input int nbeats,
                          input logic [5:0] atop, input logic [63:0] addr);
    bit ok;
    @(posedge clk); #1;
    req.aw.id = id; req.aw.len = len; req.aw.addr = addr; req.aw.atop = atop;
    req.aw_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (resp.aw_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("aw_hs_timeout", 64'd0, 64'd1);
      req.aw_valid = 1'b0;
      return;
    end
    bq.push_back(id);
    exp_cnt++;
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    req.w_valid = 1'b1; req.w.last = (nbeats == 1); req.w.data = {$urandom, $urandom};
    for (int b = 0; b < nbeats; b++) begin
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (b == 0 && k == 0) check("wready_after_aw", {63'd0, resp.w_ready}, 64'd1);
        if (resp.w_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin check("w_hs_timeout", 64'd0, 64'd1); break; end
      @(posedge clk); #1;
      if (b + 1 < nbeats) begin
        req.w.last = (b + 2 == nbeats);
        req.w.data = {$urandom, $urandom};
      end
    end
    req.w_valid = 1'b0;
    req.w.last = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] id, input logic [7:0] len, input logic [63:0] addr);
    bit ok;
    rexp_t e;
    @(posedge clk); #1;
    req.ar.id = id; req.ar.len = len; req.ar.addr = addr;
    req.ar_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (resp.ar_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("ar_hs_timeout", 64'd0, 64'd1);
      req.ar_valid = 1'b0;
      return;
    end
    for (int i = 0; i <= int'(len); i++) begin
      e.id = id;
      e.last = (i == int'(len));
      rq.push_back(e);
    end
    exp_cnt++;
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    for (int c = 0; c < 3000; c++) begin
      if (rq.size() == 0 && bq.size() == 0) break;
      @(posedge clk); #1;
      if (rnd) req.r_ready = 1'($urandom_range(0, 1));
    end
    req.r_ready = 1'b1;
    check("drain_complete", 64'(rq.size() + bq.size()), 64'd0);
  endtask

  vec_t vecs[5];

  initial begin
    int rb0, bb0;
    logic [63:0] wa;
    req = '0;
    req.b_ready = 1'b1;
    req.r_ready = 1'b1;

    vecs[0] = '{rd: 1'b0, id: 6'd5,  len: 8'd0, wbeats: 1, atop: 6'd0,  exp_beats: 1};
    vecs[1] = '{rd: 1'b1, id: 6'd3,  len: 8'd3, wbeats: 0, atop: 6'd0,  exp_beats: 4};
    vecs[2] = '{rd: 1'b0, id: 6'd9,  len: 8'd3, wbeats: 2, atop: 6'd0,  exp_beats: 1};
    vecs[3] = '{rd: 1'b1, id: 6'h3F, len: 8'd0, wbeats: 0, atop: 6'd0,  exp_beats: 1};
    vecs[4] = '{rd: 1'b0, id: 6'd2,  len: 8'd7, wbeats: 8, atop: 6'h21, exp_beats: 1};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", {63'd0, resp.aw_ready}, 64'd1);
    check("rst_arready", {63'd0, resp.ar_ready}, 64'd1);
    check("rst_wready", {63'd0, resp.w_ready}, 64'd0);
    check("rst_bvalid", {63'd0, resp.b_valid}, 64'd0);
    check("rst_rvalid", {63'd0, resp.r_valid}, 64'd0);
    check("rst_errcnt", {48'd0, err_cnt}, 64'd0);
    check("rst_errvalid", {63'd0, err_valid}, 64'd0);
    rst_n = 1'b1;

    // single write with B stalled: awready stays low until after the B handshake
    req.b_ready = 1'b0;
    do_write(6'd5, 8'd0, 1, 6'd0, 64'h2000);
    @(negedge clk);
    check("wr_bvalid_m1", {63'd0, resp.b_valid}, 64'd1);
    check("wr_bid", {58'd0, resp.b.id}, 64'd5);
    check("wr_awready_busy", {63'd0, resp.aw_ready}, 64'd0);
    repeat (2) @(negedge clk);
    check("wr_awready_stall", {63'd0, resp.aw_ready}, 64'd0);
    @(posedge clk); #1;
    req.b_ready = 1'b1;
    @(negedge clk);
    check("wr_awready_hs", {63'd0, resp.aw_ready}, 64'd0);
    @(negedge clk);
    check("wr_awready_after", {63'd0, resp.aw_ready}, 64'd1);
    check("wr_bvalid_after", {63'd0, resp.b_valid}, 64'd0);
    check("wr_errcnt", {48'd0, err_cnt}, CAP ? 64'(exp_cnt) : 64'd0);

    // read arid=3 arlen=3: beats on consecutive cycles, capture pulse after AR
    do_read(6'd3, 8'd3, 64'h1000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rd_rvalid_beat", {63'd0, resp.r_valid}, 64'd1);
      check("rd_rlast_beat", {63'd0, resp.r.last}, {63'd0, (i == 3)});
      if (i == 0) begin
        check("rd_errvalid", {63'd0, err_valid}, {63'd0, CAP});
        check("rd_erraddr", err_addr, CAP ? 64'h1000 : 64'd0);
      end
      if (i == 1) check("rd_errvalid_pulse", {63'd0, err_valid}, 64'd0);
    end
    @(negedge clk);
    check("rd_rvalid_done", {63'd0, resp.r_valid}, 64'd0);
    check("rd_arready_done", {63'd0, resp.ar_ready}, 64'd1);

    // vector table, including atomic and short-burst writes
    foreach (vecs[i]) begin
      rb0 = rbeats; bb0 = bbeats;
      if (vecs[i].rd) do_read(vecs[i].id, vecs[i].len, 64'h3000 + 64'(i));
      else do_write(vecs[i].id, vecs[i].len, vecs[i].wbeats, vecs[i].atop, 64'h4000 + 64'(i));
      drain(1'b0);
      check($sformatf("vec%0d_beats", i), 64'((rbeats - rb0) + (bbeats - bb0)),
            64'(vecs[i].exp_beats));
    end

    // concurrent write len 7 and read len 1 in the same cycle
    wa = 64'hDEAD_0000;
    rb0 = rbeats; bb0 = bbeats;
    fork
      do_write(6'd4, 8'd7, 8, 6'd0, wa);
      do_read(6'd6, 8'd1, 64'hBEEF_0000);
    join
    drain(1'b0);
    check("conc_rbeats", 64'(rbeats - rb0), 64'd2);
    check("conc_bbeats", 64'(bbeats - bb0), 64'd1);
    check("conc_erraddr", err_addr, CAP ? wa : 64'd0);
    check("conc_errcnt", {48'd0, err_cnt}, CAP ? 64'(exp_cnt) : 64'd0);

    // 256-beat read with random backpressure
    rb0 = rbeats;
    do_read(6'd12, 8'd255, 64'h5000);
    drain(1'b1);
    check("long_beats", 64'(rbeats - rb0), 64'd256);

    // reset during the 3rd beat of an 8-beat read
    rb0 = rbeats;
    do_read(6'd7, 8'd7, 64'h6000);
    for (int c = 0; c < 50; c++) begin
      if (rbeats - rb0 >= 2) break;
      @(posedge clk); #1;
    end
    check("mid_two_beats", 64'(rbeats - rb0), 64'd2);
    #1;
    rst_n = 1'b0;
    rq.delete();
    exp_cnt = 0;
    #1;
    check("mid_rst_rvalid", {63'd0, resp.r_valid}, 64'd0);
    check("mid_rst_arready", {63'd0, resp.ar_ready}, 64'd1);
    check("mid_rst_errcnt", {48'd0, err_cnt}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rb0 = rbeats;
    do_read(6'd1, 8'd0, 64'h7000);
    drain(1'b0);
    check("post_rst_beats", 64'(rbeats - rb0), 64'd1);
    check("post_rst_errcnt", {48'd0, err_cnt}, CAP ? 64'd1 : 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule

// File: doc/axi_err_slv.md
# axi_err_slv

Terminating AXI4 responder on the SoC crossbar for every address outside the `ariane_soc` map, plus regions whose `ValidRule` bit is cleared. It accepts any read or write burst from any crossbar master (CVA6, DEBUG, IOMMU_COMP, IOMMU_MEM) and completes it protocol-correctly with DECERR. It never leaves a master hung on an unmapped access. The read and write channels are served by independent state machines.

## Interface
Parameters:
- AxiIdWidth, default ariane_soc::IdWidthSlave (6): ID width on the crossbar slave side.
- AxiAddrWidth, default 64: address width.
- AxiDataWidth, default 64: data width.
- RespData, default 64'hBADC_AB1E_BADC_AB1E: constant value driven on rdata.
- req_t, default ariane_axi::req_t: AXI request struct.
- resp_t, default ariane_axi::resp_t: AXI response struct.

Ports:
- clk_i, in, 1: clock. One clock domain.
- rst_ni, in, 1: reset, asynchronous, active-low.
- axi_req_i, in, req_t: AW/W/AR channels and B/R ready signals.
- axi_resp_o, out, resp_t: channel ready signals, B and R channels.
- err_valid_o, out, 1: one-cycle pulse per captured fault. Exists only with the feature; otherwise tied 0.
- err_addr_o, out, AxiAddrWidth: address of the last faulting access. Tied 0 without the feature.
- err_cnt_o, out, 16: saturating count of faults. Tied 0 without the feature.

## Operation
Write FSM has three states: W_IDLE, W_DATA, W_RESP.
- W_IDLE:
  - awready=1.
  - On an AW handshake, latch awid and go to W_DATA.
- W_DATA:
  - wready=1. Every beat is accepted and its data discarded.
  - The beat with wlast=1 moves the FSM to W_RESP.
  - awlen is not checked against the beat count; only wlast ends the burst.
- W_RESP:
  - bvalid=1, bresp=2'b11 (DECERR), bid=latched id, buser=0.
  - On the bready handshake, return to W_IDLE.

Read FSM has two states: R_IDLE, R_DATA.
- R_IDLE:
  - arready=1.
  - On an AR handshake, latch arid and set an 8-bit beat counter to arlen. Go to R_DATA.
- R_DATA:
  - rvalid=1, rdata=RespData, rresp=DECERR, rid=latched id.
  - rlast=1 exactly when the counter is 0.
  - Each R handshake decrements the counter. The handshake with rlast moves the FSM to R_IDLE.

General rules:
- Channels are fully independent. A read and a write may be in flight at once, with at most one of each.
- Atomics (atop≠0) are treated as plain writes and get a single B response. No R beats are generated for them.
- Reset values:
  - Both FSMs are in IDLE.
  - All valid outputs are 0; awready=arready=1; wready=0.
  - Latched ids and the counter are 0.
  - Feature outputs are 0.
- Reset asserted mid-burst aborts immediately. The block returns to IDLE and no partial response is completed.

## Timing
- AW handshake at cycle N: wready=1 from N+1.
- W beat with wlast at cycle M: bvalid=1 at M+1.
- B handshake at cycle K: awready=1 at K+1. Minimum write turnaround is 3 cycles for a single beat.
- AR handshake at cycle N: first rvalid=1 at N+1.
  - With rready held high, one beat per cycle; the last beat is at N+1+arlen.
  - arready=1 again one cycle after the last-beat handshake.
- While rready=0, rvalid, rdata, rid and rlast are held stable. Same for B while bready=0.
- No combinational path from any input valid to any output ready; readies decode state only.
- arlen=255 yields exactly 256 beats; the counter must not wrap early.

## Configuration
- Macro ERR_SLV_CAPTURE_EN.
- Defined:
  - On each AW or AR handshake, register the address into err_addr_o and pulse err_valid_o for one cycle the next cycle.
  - Increment err_cnt_o, saturating at 16'hFFFF.
  - If AW and AR handshake in the same cycle, the AW address wins and err_cnt_o increments by 2.
- Undefined: capture registers are absent and the three outputs are constant 0. Channel behaviour is identical in both builds.

## Structure
- Shared package `axi_err_slv_pkg`:
  - RESP_DECERR constant.
  - Write and read state enums.
  - Default RespData constant.
- Sub-module `axi_err_slv_rd` holds the read FSM and beat counter; it is naturally separable.
- The write FSM and capture logic stay in the top module.

## Test plan
- Single write (AW id=5, len=0, W wlast): bvalid at M+1 with bid=5, bresp=2'b11. awready is low until the cycle after the B handshake.
- Read with arid=3, arlen=3, rready=1: 4 beats on consecutive cycles, rdata=64'hBADC_AB1E_BADC_AB1E, rresp=2'b11, rlast only on beat 4.
- Read with arlen=255 and rready toggled randomly: exactly 256 beats. Outputs are stable while stalled and rlast is on beat 256 only.
- Concurrent write (len=7) and read (len=1) issued in the same cycle: both complete with correct ids. err_cnt_o=2 and err_addr_o holds the AW address (capture build).
- rst_ni asserted during the 3rd beat of an 8-beat read: rvalid=0 immediately and arready=1. A subsequent read with arid=1 returns id 1.
- Bad-length write (awlen=3, wlast on beat 2): B is issued after beat 2 and the next AW is accepted normally.
